// File: rtl/rs_latch_exerciser_if.sv
// Control/status and latch-side signals of the RS latch exerciser.
// master = exerciser side, slave = board/bench side (drives Start and Q).
interface rs_latch_exerciser_if #(
  parameter int ERR_W = 4
);
  logic             Start;
  logic             Q;
  logic             R;
  logic             S;
  logic             Busy;
  logic             Done;
  logic             Pass;
  logic             Mismatch;
  logic [2:0]       Step;
  logic [ERR_W-1:0] Err_Count;

  modport master (
    input  Start, Q,
    output R, S, Busy, Done, Pass, Mismatch, Step, Err_Count
  );

  modport slave (
    output Start, Q,
    input  R, S, Busy, Done, Pass, Mismatch, Step, Err_Count
  );
endinterface

// File: rtl/rs_latch_exerciser.sv
// Steps an RS latch through a fixed R/S vector table, samples Q after a settle
// window and counts mismatches. Define RS_FORBIDDEN_EN to append the R=S=1 vectors.
module rs_latch_exerciser #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input logic                 Clk,
  input logic                 Resetn,
  rs_latch_exerciser_if.master bus
);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
`ifdef RS_FORBIDDEN_EN
  localparam logic [2:0] LAST = 3'd5;
`else
  localparam logic [2:0] LAST = 3'd3;
`endif

  // Vector table, returned as {R,S}.
  function automatic logic [1:0] vec_rs(input logic [2:0] idx);
    case (idx)
      3'd1:    return 2'b01;
      3'd2:    return 2'b10;
`ifdef RS_FORBIDDEN_EN
      3'd4:    return 2'b11;
      3'd5:    return 2'b10;
`endif
      default: return 2'b00;
    endcase
  endfunction

  // Step 0 (and the forbidden step 4) leave the latch in an unknown state.
  function automatic logic vec_chk(input logic [2:0] idx);
    case (idx)
      3'd1, 3'd2, 3'd3: return 1'b1;
`ifdef RS_FORBIDDEN_EN
      3'd5:             return 1'b1;
`endif
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic vec_exp(input logic [2:0] idx);
    return (idx == 3'd1);
  endfunction

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       rs, rs_n;
  logic [2:0]       step, step_n;
  logic [ERR_W-1:0] err, err_n;
  logic             busy, busy_n;
  logic             done, done_n;
  logic             pass, pass_n;
  logic             mismatch, mismatch_n;

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (which would infer a latch).
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rs_n       = rs;
    step_n     = step;
    err_n      = err;
    mismatch_n = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (bus.Start) begin
          state_n = DRIVE;
          step_n  = 3'd0;
          err_n   = '0;
        end
      end
      DRIVE: begin
        rs_n    = vec_rs(step);
        cnt_n   = '0;
        state_n = SETTLE;
      end
      SETTLE: begin
        if (cnt == CNT_LAST) state_n = SAMPLE;
        else                 cnt_n   = cnt + 1'b1;
      end
      SAMPLE: begin
        if (vec_chk(step) && (bus.Q != vec_exp(step))) begin
          mismatch_n = 1'b1;
          if (err != ERR_MAX) err_n = err + 1'b1;
        end
        if (step == LAST) begin
          state_n = DONE;
        end else begin
          step_n  = step + 3'd1;
          state_n = DRIVE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_n = (state_n == DRIVE) || (state_n == SETTLE) || (state_n == SAMPLE);
    done_n = (state_n == DONE);
    pass_n = done_n && (err_n == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      rs       <= 2'b00;
      step     <= 3'd0;
      err      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rs       <= rs_n;
      step     <= step_n;
      err      <= err_n;
      busy     <= busy_n;
      done     <= done_n;
      pass     <= pass_n;
      mismatch <= mismatch_n;
    end
  end

  assign bus.R         = rs[1];
  assign bus.S         = rs[0];
  assign bus.Busy      = busy;
  assign bus.Done      = done;
  assign bus.Pass      = pass;
  assign bus.Mismatch  = mismatch;
  assign bus.Step      = step;
  assign bus.Err_Count = err;

endmodule

// File: tb/tb_rs_latch_exerciser.sv
// Bench for rs_latch_exerciser: random runs against several latch behaviours,
// random restarts and mid-run resets, checked cycle by cycle against a table model.
module tb_rs_latch_exerciser;

  localparam int SETTLE = 2;
  localparam int PER    = SETTLE + 2;
`ifdef RS_FORBIDDEN_EN
  localparam int NVEC = 6;
`else
  localparam int NVEC = 4;
`endif
  localparam int NCLK = NVEC * PER;

  logic Clk = 1'b0;
  logic Resetn;
  always #5 Clk = ~Clk;

  rs_latch_exerciser_if #(.ERR_W(4)) bus  ();
  rs_latch_exerciser_if #(.ERR_W(1)) bus1 ();

  rs_latch_exerciser #(.SETTLE_CYCLES(SETTLE), .ERR_W(4)) dut (
    .Clk(Clk), .Resetn(Resetn), .bus(bus.master));
  rs_latch_exerciser #(.SETTLE_CYCLES(SETTLE), .ERR_W(1)) dut1 (
    .Clk(Clk), .Resetn(Resetn), .bus(bus1.master));

  // Latch models: 0 ideal, 1 stuck-at-0, 2 stuck-at-1, 3 inverted output.
  int   mode = 0;
  logic latch_q = 1'b1;
  always @(posedge Clk) begin
    case ({bus.R, bus.S})
      2'b01:        latch_q <= 1'b1;
      2'b10, 2'b11: latch_q <= 1'b0;
      default:      latch_q <= latch_q;
    endcase
  end
  assign bus.Q = (mode == 0) ? latch_q : (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : ~latch_q;
  assign bus1.Start = bus.Start;
  assign bus1.Q     = 1'b1;

  // Reference table: {R,S}, checked flag, expected Q.
  logic [1:0] t_rs  [NVEC];
  bit         t_chk [NVEC];
  bit         t_exp [NVEC];
  bit         fail_v[NVEC];
  int         stuck1_fails;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] prev_rs;
  bit idle_done, idle_pass, last_keep;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Predict which vectors fail for a latch behaviour, from the latch truth table.
  task automatic plan_run(input int m);
    bit st = 1'b0;
    bit qv;
    for (int v = 0; v < NVEC; v++) begin
      if (t_rs[v] == 2'b01) st = 1'b1;
      else if (t_rs[v] != 2'b00) st = 1'b0;
      qv = (m == 0) ? st : (m == 1) ? 1'b0 : (m == 2) ? 1'b1 : ~st;
      fail_v[v] = t_chk[v] && (qv != t_exp[v]);
    end
  endtask

  function automatic int fails_before(input int nv, input int sat);
    int c = 0;
    for (int v = 0; v < nv; v++) c += int'(fail_v[v]);
    return (c > sat) ? sat : c;
  endfunction

  // Idle cycles in IDLE/DONE, then Start=1 so the next edge launches a run.
  task automatic arm_start(input int idle_cycles);
    bus.Start = 1'b0;
    for (int i = 0; i < idle_cycles; i++) begin
      @(posedge Clk); #1;
      check("idle_busy", bus.Busy, 0);
      check("idle_done", bus.Done, idle_done);
      check("idle_pass", bus.Pass, idle_pass);
    end
    bus.Start = 1'b1;
  endtask

  // One run; Start is already high. abort_k >= 0 pulls reset after that edge.
  task automatic do_run(input int abort_k, input bit keep_start);
    logic [1:0] exp_rs;
    plan_run(mode);
    for (int k = 0; k <= NCLK; k++) begin
      @(posedge Clk); #1;
      if (k % PER == 0) exp_rs = (k == 0) ? prev_rs : t_rs[k/PER - 1];
      else              exp_rs = t_rs[k/PER];
      check("rs", {bus.R, bus.S}, exp_rs);
      check("mismatch", bus.Mismatch, (k % PER == 0 && k > 0) ? fail_v[k/PER - 1] : 1'b0);
      check("err_count", bus.Err_Count, fails_before(k / PER, 15));
      if (k < NCLK) begin
        check("busy", bus.Busy, 1);
        check("done", bus.Done, 0);
        check("pass_run", bus.Pass, 0);
        check("step", bus.Step, k / PER);
      end else begin
        check("end_busy", bus.Busy, 0);
        check("end_done", bus.Done, 1);
        check("end_pass", bus.Pass, fails_before(NVEC, 15) == 0);
        check("end_step", bus.Step, NVEC - 1);
        check("sat_err", bus1.Err_Count, (stuck1_fails > 0) ? 1 : 0);
        check("sat_pass", bus1.Pass, stuck1_fails == 0);
      end
      if (k == abort_k) begin
        Resetn = 1'b0;
        #1;
        check("abort_rs", {bus.R, bus.S}, 2'b00);
        check("abort_busy", bus.Busy, 0);
        check("abort_err", bus.Err_Count, 0);
        check("abort_step", bus.Step, 0);
        check("abort_done", bus.Done, 0);
        bus.Start = 1'b0;
        @(negedge Clk);
        Resetn    = 1'b1;
        prev_rs   = 2'b00;
        idle_done = 1'b0;
        idle_pass = 1'b0;
        last_keep = 1'b0;
        return;
      end
      // Start toggling while busy must be ignored.
      bus.Start = (k < NCLK) ? 1'($urandom_range(0, 1)) : keep_start;
    end
    prev_rs   = t_rs[NVEC-1];
    idle_done = 1'b1;
    idle_pass = (fails_before(NVEC, 15) == 0);
    last_keep = keep_start;
  endtask

  task automatic run(input int m, input int abort_k, input bit keep_start);
    if (!last_keep) arm_start(int'($urandom_range(1, 3)));
    mode = m;
    do_run(abort_k, keep_start);
  endtask

  initial begin
    for (int v = 0; v < NVEC; v++) begin
      t_rs[v]  = 2'b00;
      t_chk[v] = 1'b0;
      t_exp[v] = 1'b0;
    end
    t_rs[1] = 2'b01; t_chk[1] = 1'b1; t_exp[1] = 1'b1;
    t_rs[2] = 2'b10; t_chk[2] = 1'b1;
    t_rs[3] = 2'b00; t_chk[3] = 1'b1;
`ifdef RS_FORBIDDEN_EN
    t_rs[4] = 2'b11;
    t_rs[5] = 2'b10; t_chk[5] = 1'b1;
`endif
    stuck1_fails = 0;
    for (int v = 0; v < NVEC; v++)
      if (t_chk[v] && !t_exp[v]) stuck1_fails++;

    Resetn    = 1'b0;
    bus.Start = 1'b0;
    prev_rs   = 2'b00;
    idle_done = 1'b0;
    idle_pass = 1'b0;
    last_keep = 1'b0;
    #12;
    check("rst_rs", {bus.R, bus.S}, 2'b00);
    check("rst_busy", bus.Busy, 0);
    check("rst_done", bus.Done, 0);
    check("rst_pass", bus.Pass, 0);
    check("rst_mismatch", bus.Mismatch, 0);
    check("rst_step", bus.Step, 0);
    check("rst_err", bus.Err_Count, 0);
    @(negedge Clk);
    Resetn = 1'b1;

    run(0, -1, 1'b0);             // ideal latch
    run(1, -1, 1'b0);             // Q stuck-at-0
    run(2, -1, 1'b0);             // Q stuck-at-1
    run(0, 2 * PER + 1, 1'b0);    // reset during step 2 settle
    run(0, -1, 1'b0);             // clean run after abort
    run(3, -1, 1'b1);             // Start held into DONE
    run(0, -1, 1'b0);             // back-to-back restart

    for (int i = 0; i < 24; i++) begin
      int m  = int'($urandom_range(0, 3));
      int ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, NCLK - 1)) : -1;
      run(m, ab, 1'($urandom_range(0, 1)));
    end
    last_keep = 1'b0;
    arm_start(2);
    bus.Start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
